// File: rtl/vc_buffer_arb.sv
// ---------------------------------------------------------------------------
// vc_buffer_arb
//
// Purpose:
//   Two virtual-channel flit buffers (VC0 = transit, VC1 = NI injection)
//   draining onto a single output link through a packet-locked round-robin
//   arbiter. Once a VC is granted, the link stays with it until that VC's
//   trailer flit (TRAILER) has been accepted downstream. Only the trailer
//   matters to the arbiter, so head-flit tags are never decoded here.
//
// Ports:
//   clk             in   1  single clock, all state on the rising edge
//   rst             in   1  synchronous, active-high reset
//   flit_in         in   8  flit from the switch controller (8'h00 = idle)
//   vc_sel          in   2  2'b01 -> VC0, 2'b10 -> VC1, other codes -> no write
//   sel_vc          in   1  write strobe
//   flit_out        out  8  head-of-queue flit of granted VC, 8'h00 if not valid
//   flit_out_valid  out  1  flit_out holds a valid flit
//   flit_out_ready  in   1  downstream accepts flit_out this cycle
//   full_vc         out  2  [i]=1 when VCi holds DEPTH flits
//   empty_vc        out  2  [i]=1 when VCi holds no flits
//   grant_vc        out  1  granted VC (meaningful while pkt_active=1)
//   pkt_active      out  1  arbiter locked to a packet
//   overflow        out  1  one-cycle pulse: a write was dropped (target full)
// ---------------------------------------------------------------------------
module vc_buffer_arb #(
    parameter int         DEPTH   = 4,      // flits per VC, power of two, >= 2
    parameter logic [7:0] TRAILER = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flit_in,
    input  logic [1:0] vc_sel,
    input  logic       sel_vc,
    output logic [7:0] flit_out,
    output logic       flit_out_valid,
    input  logic       flit_out_ready,
    output logic [1:0] full_vc,
    output logic [1:0] empty_vc,
    output logic       grant_vc,
    output logic       pkt_active,
    output logic       overflow
);

    localparam int             PTR_W     = $clog2(DEPTH);
    localparam int             CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Arbiter state
    logic [0:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_q, rr_d;          // VC that wins the next tie
    logic       overflow_q, overflow_d;

    // Write decode and per-VC status
    logic       wr_req;
    logic [1:0] wr_hit;              // valid write addressed to VCi
    logic [1:0] wr_en;               // write actually accepted into VCi
    logic [1:0] pop_en;
    logic [1:0] full_w;
    logic [1:0] empty_w;
    logic [7:0] head_vc [2];
    logic [7:0] head_flit;
    logic       out_valid;
    logic       pop;

    assign wr_req    = sel_vc && (flit_in != 8'h00);
    assign wr_hit[0] = wr_req && (vc_sel == 2'b01);
    assign wr_hit[1] = wr_req && (vc_sel == 2'b10);

    // Full blocks a write even if the same VC pops this cycle, so a full
    // FIFO never has to forward a flit through in a single cycle.
    assign wr_en      = wr_hit & ~full_w;
    assign overflow_d = |(wr_hit & full_w);

    assign head_flit = head_vc[grant_q];
    assign out_valid = (state_q == ST_SEND) && !empty_w[grant_q];
    assign pop       = out_valid && flit_out_ready;

    // -----------------------------------------------------------------------
    // Per-VC circular FIFOs
    // -----------------------------------------------------------------------
    for (genvar v = 0; v < 2; v++) begin : g_vc
        logic [7:0]       mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign full_w[v]  = (cnt_q == DEPTH_CNT);
        assign empty_w[v] = (cnt_q == '0);
        assign pop_en[v]  = pop && (grant_q == 1'(v));
        assign head_vc[v] = mem_q[rd_ptr_q];

        // NOTE: every signal assigned in an always_comb gets a default at the
        // top of the block, so no path leaves it unassigned and no latch is
        // inferred.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (wr_en[v]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en[v]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en[v], pop_en[v]})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;   // idle, or write+pop cancel out
            endcase
        end

        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples values from before the edge, independent of
        // statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // NOTE: the storage array has no reset; emptiness is tracked by the
        // count and pointers, so stale contents are never observable.
        always_ff @(posedge clk) begin
            if (wr_en[v]) mem_q[wr_ptr_q] <= flit_in;
        end
    end

    // -----------------------------------------------------------------------
    // Packet-locked round-robin arbiter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_w[0] && !empty_w[1]) begin
                    state_d = ST_SEND;
                    grant_d = rr_q;
                end else if (!empty_w[0]) begin
                    state_d = ST_SEND;
                    grant_d = 1'b0;
                end else if (!empty_w[1]) begin
                    state_d = ST_SEND;
                    grant_d = 1'b1;
                end
            end
            ST_SEND: begin
                // The lock is released only when the trailer leaves; an
                // empty granted VC just stalls the link.
                if (pop && (head_flit == TRAILER)) begin
                    state_d = ST_IDLE;
                    rr_d    = ~grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

    assign flit_out       = out_valid ? head_flit : 8'h00;
    assign flit_out_valid = out_valid;
    assign full_vc        = full_w;
    assign empty_vc       = empty_w;
    assign grant_vc       = grant_q;
    assign pkt_active     = (state_q == ST_SEND);
    assign overflow       = overflow_q;

endmodule
